keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 190 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column drive, per-key debounce, press/release event buffer.
// Define KEYPAD_EVT_FIFO_EN for a 4-entry event FIFO; otherwise a single holding register.

module keypad_deb_cell #(
  parameter int DEB_CNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic smp,
  output logic key_q,
  output logic flip
);
  logic [3:0] cnt;

  assign flip = en && (smp != key_q) && (cnt == 4'(DEB_CNT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      key_q <= 1'b0;
    end else if (en) begin
      if (smp == key_q) begin
        cnt <= '0;
      end else if (flip) begin
        key_q <= ~key_q;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end
endmodule

module keypad_scanner #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEB_CNT  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ROWS-1:0]                kb_row,
  output logic [COLS-1:0]                kb_col,
  output logic [ROWS*COLS-1:0]           key,
  output logic                           evt_valid,
  input  logic                           evt_ready,
  output logic [$clog2(ROWS*COLS)-1:0]   evt_code,
  output logic                           evt_press,
  output logic                           evt_ovf,
  input  logic                           ovf_clr
);
  localparam int NK         = ROWS * COLS;
  localparam int KW         = $clog2(NK);
  localparam int RW         = $clog2(ROWS);
  localparam int CW         = $clog2(COLS);
  localparam int DW         = $clog2(SCAN_DIV);
  localparam int DWELL_CYC  = SCAN_DIV - ROWS - 2;
  localparam int DWELL_LAST = (DWELL_CYC > 0) ? DWELL_CYC - 1 : 0;

  typedef enum logic [1:0] {S_DWELL, S_SAMPLE, S_UPDATE, S_NEXT} state_t;
  typedef struct packed {
    logic [KW-1:0] code;
    logic          press;
  } evt_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   dwell_cnt;
  logic [RW-1:0]   row_idx;
  logic [CW-1:0]   col;
  logic [ROWS-1:0] row_smp;
  logic            sample_en, upd_en, next_en;
  logic [KW-1:0]   k_idx;
  logic [NK-1:0]   flip;
  logic            push, pop, full, accept, drop;
  evt_t            push_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_DWELL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_DWELL:  if (dwell_cnt >= DW'(DWELL_LAST)) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = S_UPDATE;
      S_UPDATE: if (row_idx == RW'(ROWS - 1)) state_nxt = S_NEXT;
      S_NEXT:   state_nxt = (DWELL_CYC == 0) ? S_SAMPLE : S_DWELL;
      default:  state_nxt = S_DWELL;
    endcase
  end

  always_comb begin
    sample_en = (state == S_SAMPLE);
    upd_en    = (state == S_UPDATE);
    next_en   = (state == S_NEXT);
    kb_col    = ~(COLS'(1) << col);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt <= '0;
      row_idx   <= '0;
      col       <= '0;
      row_smp   <= '1;
    end else begin
      dwell_cnt <= (state == S_DWELL) ? dwell_cnt + DW'(1) : '0;
      if (upd_en && row_idx != RW'(ROWS - 1)) row_idx <= row_idx + RW'(1);
      else                                    row_idx <= '0;
      if (next_en) col <= (col == CW'(COLS - 1)) ? '0 : col + CW'(1);
      if (sample_en) row_smp <= kb_row;
    end
  end

  assign k_idx = KW'(int'(row_idx) * COLS + int'(col));

  // Only the key under the current (row, column) is enabled, so at most one flips per clock.
  for (genvar k = 0; k < NK; k++) begin : g_key
    keypad_deb_cell #(.DEB_CNT(DEB_CNT)) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (upd_en && (k_idx == KW'(k))),
      .smp   (~row_smp[k / COLS]),
      .key_q (key[k]),
      .flip  (flip[k])
    );
  end

  assign push           = |flip;
  assign push_evt.code  = k_idx;
  assign push_evt.press = ~row_smp[row_idx];
  assign pop            = evt_valid && evt_ready;
  assign accept         = push && (!full || pop);
  assign drop           = push && full && !pop;

`ifdef KEYPAD_EVT_FIFO_EN
  evt_t       fifo [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;

  assign full      = (count == 3'd4);
  assign evt_valid = (count != 3'd0);
  assign evt_code  = fifo[rd_ptr].code;
  assign evt_press = fifo[rd_ptr].press;

  always_ff @(posedge clk) begin
    if (accept) fifo[wr_ptr] <= push_evt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 2'd1;
      if (pop)    rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'(accept) - 3'(pop);
    end
  end
`else
  evt_t hold;
  logic hold_vld;

  assign full      = hold_vld;
  assign evt_valid = hold_vld;
  assign evt_code  = hold.code;
  assign evt_press = hold.press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold     <= '0;
      hold_vld <= 1'b0;
    end else if (accept) begin
      hold     <= push_evt;
      hold_vld <= 1'b1;
    end else if (pop) begin
      hold_vld <= 1'b0;
    end
  end
`endif

  // A drop in the same clock as ovf_clr leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       evt_ovf <= 1'b0;
    else if (drop)    evt_ovf <= 1'b1;
    else if (ovf_clr) evt_ovf <= 1'b0;
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: physical keypad matrix plus a per-column-period reference model.
module tb_keypad_scanner;
  localparam int ROWS = 4, COLS = 4, SCAN_DIV = 8, DEB = 3;
`ifdef KEYPAD_EVT_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, evt_ready = 1'b1, ovf_clr = 1'b0;
  logic [3:0]  kb_row, kb_col, evt_code;
  logic [15:0] key, pressed = '0;
  logic        evt_valid, evt_press, evt_ovf;

  int          n_cmp = 0, n_err = 0, cyc = 0;
  logic [15:0] mkey;
  int          mcnt [16];
  int          mcol;
  logic [4:0]  exp_q [$];
  logic [4:0]  dut_q [$];
  int          cyc_q [$];

  keypad_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEB_CNT(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .kb_row(kb_row), .kb_col(kb_col), .key(key),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_press(evt_press), .evt_ovf(evt_ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A pressed key pulls its row low while its column is driven low.
  always_comb begin
    kb_row = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!kb_col[c] && pressed[r*COLS+c]) kb_row[r] = 1'b0;
  end

  always @(negedge clk)
    if (rst_n && evt_valid && evt_ready) begin
      dut_q.push_back({evt_code, evt_press});
      cyc_q.push_back(cyc);
    end

  function automatic void model_reset();
    mkey = '0;
    mcol = 0;
    for (int k = 0; k < 16; k++) mcnt[k] = 0;
    exp_q.delete();
  endfunction

  // One column period: each key of the column sees one sample of the matrix.
  function automatic void model_period();
    int k;
    for (int r = 0; r < ROWS; r++) begin
      k = r * COLS + mcol;
      if (pressed[k] == mkey[k]) mcnt[k] = 0;
      else begin
        mcnt[k]++;
        if (mcnt[k] == DEB) begin
          mkey[k] = ~mkey[k];
          mcnt[k] = 0;
          exp_q.push_back({4'(k), mkey[k]});
        end
      end
    end
    mcol = (mcol + 1) % COLS;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      repeat (SCAN_DIV) @(posedge clk);
      @(negedge clk);
      model_period();
    end
  endtask

  task automatic align(input int c);
    while (mcol != c) step(1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    dut_q.delete();
    cyc_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (key !== 16'h0) begin n_err++; $display("FAIL reset_key got %h want 0", key); end
    n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", evt_valid); end
    n_cmp++; if (evt_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", evt_ovf); end
    n_cmp++; if (kb_col !== 4'b1110) begin n_err++; $display("FAIL reset_col got %b want 1110", kb_col); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    logic [3:0] exp_col;
    for (int p = 0; p < 5; p++) begin
      exp_col = ~(4'b0001 << (p % COLS));
      for (int i = 0; i < SCAN_DIV; i++) begin
        n_cmp++;
        if (kb_col !== exp_col) begin
          n_err++; $display("FAIL scan_col p=%0d i=%0d got %b want %b", p, i, kb_col, exp_col);
        end
        @(posedge clk);
        @(negedge clk);
      end
      model_period();
    end
  endtask

  task automatic test_press_release();
    align(0);
    dut_q.delete(); exp_q.delete();
    pressed[9] = 1'b1;
    for (int p = 0; p < 12; p++) begin
      step(1);
      n_cmp++;
      if (key !== mkey) begin n_err++; $display("FAIL press_key p=%0d got %h want %h", p, key, mkey); end
    end
    n_cmp++; if (key !== 16'h0200) begin n_err++; $display("FAIL press_final got %h want 0200", key); end
    pressed[9] = 1'b0;
    for (int p = 0; p < 12; p++) begin
      step(1);
      n_cmp++;
      if (key !== mkey) begin n_err++; $display("FAIL release_key p=%0d got %h want %h", p, key, mkey); end
    end
    n_cmp++;
    if (dut_q.size() != 2 || exp_q.size() != 2) begin
      n_err++; $display("FAIL press_evt_count got %0d want 2 (model %0d)", dut_q.size(), exp_q.size());
    end else begin
      n_cmp++; if (dut_q[0] !== 5'b10011) begin n_err++; $display("FAIL press_evt0 got %b want 10011", dut_q[0]); end
      n_cmp++; if (dut_q[1] !== 5'b10010) begin n_err++; $display("FAIL press_evt1 got %b want 10010", dut_q[1]); end
    end
  endtask

  task automatic test_glitch();
    bit pat [7] = '{1, 0, 1, 1, 0, 1, 1};
    dut_q.delete(); exp_q.delete();
    for (int i = 0; i < 7; i++) begin
      align(3);
      pressed[3] = pat[i];
      step(1);
      pressed[3] = 1'b0;
      n_cmp++;
      if (key !== 16'h0) begin n_err++; $display("FAIL glitch_key i=%0d got %h want 0", i, key); end
    end
    n_cmp++;
    if (dut_q.size() != 0 || exp_q.size() != 0) begin
      n_err++; $display("FAIL glitch_evt got %0d want 0 (model %0d)", dut_q.size(), exp_q.size());
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] want [4] = '{4'd0, 4'd4, 4'd8, 4'd12};
    align(0);
    dut_q.delete(); cyc_q.delete(); exp_q.delete();
    pressed = 16'h1111;
    step(9);
    n_cmp++;
    if (dut_q.size() != 4) begin
      n_err++; $display("FAIL simul_count got %0d want 4", dut_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (dut_q[i] !== {want[i], 1'b1} || dut_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL simul_evt i=%0d got %b want %b", i, dut_q[i], {want[i], 1'b1});
        end
      end
      for (int i = 1; i < 4; i++) begin
        n_cmp++;
        if (cyc_q[i] - cyc_q[i-1] != 1) begin
          n_err++; $display("FAIL simul_gap i=%0d got %0d want 1", i, cyc_q[i] - cyc_q[i-1]);
        end
      end
    end
    pressed = '0;
    step(12);
    n_cmp++; if (key !== mkey) begin n_err++; $display("FAIL simul_release got %h want %h", key, mkey); end
  endtask

  task automatic test_overflow();
    logic [4:0] kept [$];
    align(0);
    dut_q.delete(); exp_q.delete();
    evt_ready = 1'b0;
    pressed   = 16'h1133;
    step(12);
    n_cmp++; if (key !== mkey) begin n_err++; $display("FAIL ovf_key got %h want %h", key, mkey); end
    n_cmp++; if (evt_valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid got %b want 1", evt_valid); end
    n_cmp++; if (evt_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", evt_ovf); end
    n_cmp++;
    if ({evt_code, evt_press} !== exp_q[0]) begin
      n_err++; $display("FAIL ovf_head got %b want %b", {evt_code, evt_press}, exp_q[0]);
    end
    for (int i = 0; i < CAP; i++) kept.push_back(exp_q[i]);
    exp_q.delete();
    evt_ready = 1'b1;
    step(1);
    n_cmp++;
    if (dut_q.size() != CAP) begin
      n_err++; $display("FAIL ovf_queued got %0d want %0d", dut_q.size(), CAP);
    end else begin
      for (int i = 0; i < CAP; i++) begin
        n_cmp++;
        if (dut_q[i] !== kept[i]) begin n_err++; $display("FAIL ovf_drain i=%0d got %b want %b", i, dut_q[i], kept[i]); end
      end
    end
    n_cmp++; if (evt_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", evt_ovf); end
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    n_cmp++; if (evt_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clr got %b want 0", evt_ovf); end
    dut_q.delete();
    pressed = '0;
    step(12);
    n_cmp++;
    if (dut_q.size() != 6 || exp_q.size() != 6) begin
      n_err++; $display("FAIL ovf_release_count got %0d want 6 (model %0d)", dut_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (dut_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovf_release i=%0d got %b want %b", i, dut_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    align(0);
    dut_q.delete(); exp_q.delete();
    pressed[0] = 1'b1;
    step(9);
    n_cmp++; if (key !== 16'h0001) begin n_err++; $display("FAIL rmid_pre got %h want 0001", key); end
    align(0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (key !== 16'h0) begin n_err++; $display("FAIL rmid_key got %h want 0", key); end
    n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %b want 0", evt_valid); end
    n_cmp++; if (kb_col !== 4'b1110) begin n_err++; $display("FAIL rmid_col got %b want 1110", kb_col); end
    do_reset();
    for (int p = 0; p < 12; p++) begin
      step(1);
      n_cmp++;
      if (key !== mkey) begin n_err++; $display("FAIL rmid_redetect p=%0d got %h want %h", p, key, mkey); end
    end
    n_cmp++;
    if (dut_q.size() != 1 || dut_q[0] !== 5'b00001) begin
      n_err++; $display("FAIL rmid_evt got %0d events want 1 x 00001", dut_q.size());
    end
    pressed = '0;
    step(12);
  endtask

  task automatic test_random();
    dut_q.delete(); exp_q.delete();
    for (int p = 0; p < 80; p++) begin
      if ($urandom_range(0, 9) < 4) pressed[$urandom_range(0, 15)] ^= 1'b1;
      step(1);
      n_cmp++;
      if (key !== mkey) begin n_err++; $display("FAIL rand_key p=%0d got %h want %h", p, key, mkey); end
    end
    pressed = '0;
    step(12);
    n_cmp++;
    if (dut_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rand_evt_count got %0d want %0d", dut_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (dut_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_evt i=%0d got %b want %b", i, dut_q[i], exp_q[i]); end
      end
    end
    n_cmp++; if (evt_ovf !== 1'b0) begin n_err++; $display("FAIL rand_ovf got %b want 0", evt_ovf); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_press_release();
    test_glitch();
    test_simultaneous();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
